run_controller: RTL

//  Sequences the single-cycle RISC-V datapath by gating its state updates (PC, register file, RAM, parallel_out).

---
 rtl/run_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// run_controller: issues one-cycle cpu_en commit pulses for the datapath (prescaled free run,
// debounced single step, external halt). Define BREAKPOINT_EN to build the PC breakpoint and BREAK state.
module run_controller #(
  parameter int DIV_COUNT  = 2500000,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [7:0]       pc,
  input  logic [7:0]       bp_addr,
  input  logic             bp_en,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int PRE_W = (DIV_COUNT  > 1) ? $clog2(DIV_COUNT)  : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_COUNT - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             cpu_en_q, cpu_en_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             press_q, press_d;
  logic             bp_hit;
  logic             tick;

  assign tick = (presc_q == PRE_LAST);

  // Debounce: the accepted level follows the synchronized button only after a full stable run.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    press_d = deb_level_q & ~deb_level_d;
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cpu_en_d = 1'b0;
    cnt_d    = cpu_en_q ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      S_HALT: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (press_q) begin
          state_d = S_STEP;
        end else if (run_sw) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (halt_req || !run_sw) begin
          state_d = S_HALT;
        end else if (tick) begin
          presc_d = '0;
          if (bp_hit) begin
            state_d = S_BREAK;
          end else begin
            cpu_en_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      S_STEP: begin
        cpu_en_d = 1'b1;
        state_d  = S_HALT;
      end
      S_BREAK: begin
        if (halt_req || !run_sw) begin
          state_d = S_HALT;
        end else if (press_q) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_HALT;
    endcase
    halted_d = (state_d == S_HALT) || (state_d == S_BREAK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HALT;
      presc_q     <= '0;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b1;
      cnt_q       <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_level_q <= 1'b1;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cpu_en_q    <= cpu_en_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      sync1_q     <= step_btn;
      sync2_q     <= sync1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
    end
  end

`ifdef BREAKPOINT_EN
  logic       bp_block_q;
  logic [7:0] bp_pc_q;
  logic       bp_enter;

  // After a break, the same PC cannot re-trigger until the datapath moves off it.
  assign bp_hit   = bp_en && (pc == bp_addr) && !(bp_block_q && (pc == bp_pc_q));
  assign bp_enter = (state_q == S_RUN) && (state_d == S_BREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_block_q <= 1'b0;
    end else if (bp_enter) begin
      bp_block_q <= 1'b1;
    end else if (pc != bp_pc_q) begin
      bp_block_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (bp_enter) begin
      bp_pc_q <= pc;
    end
  end
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_en};
`endif

  assign cpu_en      = cpu_en_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule
